// File: rtl/buttons_pkg.sv
// Shared types for the button event unit: event kinds, per-button FSM states and the queued event record.
package buttons_pkg;

  typedef enum logic [1:0] {
    PRESS   = 2'd0,
    RELEASE = 2'd1,
    LONG    = 2'd2,
    REPEAT  = 2'd3
  } event_kind_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } button_state_t;

  // Index width of the queued record, sized for the default four buttons.
  localparam int BUTTON_IDX_W = 2;

  typedef struct packed {
    logic [BUTTON_IDX_W-1:0] button;
    event_kind_t             kind;
  } button_event_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_fsm.sv
// Per-button press/release/long/repeat FSM with its one-entry pending event slot.
// Auto-repeat in HELD is built only when BUTTONS_AUTOREPEAT_EN is defined.
module button_event_fsm
  import buttons_pkg::*;
#(
  parameter int LONG_PRESS_TICKS = 5_000_000,
  parameter int REPEAT_TICKS     = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        level,
  input  logic        slot_clear,
  output logic        slot_valid,
  output event_kind_t slot_kind,
  output logic        drop
);

  localparam int CNT_W = $clog2(max_int(LONG_PRESS_TICKS, REPEAT_TICKS));
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_TICKS - 1);
`ifdef BUTTONS_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
`endif

  button_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        slot_valid_q, slot_valid_d;
  event_kind_t slot_kind_q, slot_kind_d;
  logic        gen;
  event_kind_t gen_kind;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gen          = 1'b0;
    gen_kind     = PRESS;
    slot_valid_d = slot_valid_q;
    slot_kind_d  = slot_kind_q;
    drop         = 1'b0;

    case (state_q)
      IDLE: begin
        if (level) begin
          state_d  = PRESSED;
          cnt_d    = '0;
          gen      = 1'b1;
          gen_kind = PRESS;
        end
      end
      PRESSED: begin
        if (!level) begin
          state_d  = IDLE;
          cnt_d    = '0;
          gen      = 1'b1;
          gen_kind = RELEASE;
        end else if (cnt_q == LONG_LAST) begin
          state_d  = HELD;
          cnt_d    = '0;
          gen      = 1'b1;
          gen_kind = LONG;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!level) begin
          state_d  = IDLE;
          cnt_d    = '0;
          gen      = 1'b1;
          gen_kind = RELEASE;
        end
`ifdef BUTTONS_AUTOREPEAT_EN
        else if (cnt_q == REPEAT_LAST) begin
          cnt_d    = '0;
          gen      = 1'b1;
          gen_kind = REPEAT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // A slot being pushed this cycle counts as free for a new event.
    if (slot_clear) slot_valid_d = 1'b0;
    if (gen) begin
      if (slot_valid_q && !slot_clear) begin
        drop = 1'b1;
      end else begin
        slot_valid_d = 1'b1;
        slot_kind_d  = gen_kind;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      slot_valid_q <= 1'b0;
      slot_kind_q  <= PRESS;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      slot_valid_q <= slot_valid_d;
      slot_kind_q  <= slot_kind_d;
    end
  end

  assign slot_valid = slot_valid_q;
  assign slot_kind  = slot_kind_q;

endmodule

// File: rtl/buttons_event_unit.sv
// Button event unit top: per-button FSMs, fixed-priority arbiter, event FIFO and sticky overflow flag.
// Optional auto-repeat is enabled by defining BUTTONS_AUTOREPEAT_EN.
module buttons_event_unit
  import buttons_pkg::*;
#(
  parameter int BUTTON_COUNT     = 4,
  parameter int LONG_PRESS_TICKS = 5_000_000,
  parameter int REPEAT_TICKS     = 1_000_000,
  parameter int FIFO_DEPTH       = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [BUTTON_COUNT-1:0]         buttons,
  output logic                            event_valid,
  output logic [$clog2(BUTTON_COUNT)-1:0] event_button,
  output event_kind_t                     event_kind,
  input  logic                            event_pop,
  output logic                            overflow,
  input  logic                            overflow_clear
);

  localparam int IDX_W = $clog2(BUTTON_COUNT);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;

  logic [BUTTON_COUNT-1:0] slot_valid, slot_clear, drop;
  event_kind_t             slot_kind [BUTTON_COUNT];

  for (genvar gi = 0; gi < BUTTON_COUNT; gi++) begin : g_btn
    button_event_fsm #(
      .LONG_PRESS_TICKS(LONG_PRESS_TICKS),
      .REPEAT_TICKS    (REPEAT_TICKS)
    ) u_fsm (
      .clk       (clk),
      .rst       (rst),
      .level     (buttons[gi]),
      .slot_clear(slot_clear[gi]),
      .slot_valid(slot_valid[gi]),
      .slot_kind (slot_kind[gi]),
      .drop      (drop[gi])
    );
  end

  button_event_t   mem_q [FIFO_DEPTH];
  button_event_t   mem_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            overflow_q, overflow_d;
  logic [IDX_W-1:0] win_idx;
  logic            win_found, fifo_empty, fifo_full, do_pop, do_push;
  button_event_t   head;

  // Lowest-indexed full slot wins; scanning downward leaves the lowest one last.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = BUTTON_COUNT - 1; i >= 0; i--) begin
      if (slot_valid[i]) begin
        win_idx   = IDX_W'(i);
        win_found = 1'b1;
      end
    end
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop     = event_pop && !fifo_empty;
  assign do_push    = win_found && (!fifo_full || do_pop);
  assign slot_clear = do_push ? (BUTTON_COUNT'(1) << win_idx) : '0;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = '{button: BUTTON_IDX_W'(win_idx), kind: slot_kind[win_idx]};
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
    overflow_d = (|drop) ? 1'b1 : (overflow_clear ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  assign head         = mem_q[rd_ptr_q[AW-1:0]];
  assign event_valid  = !fifo_empty;
  assign event_button = fifo_empty ? '0 : IDX_W'(head.button);
  assign event_kind   = fifo_empty ? PRESS : head.kind;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_buttons_event_unit.sv
// Self-checking bench for buttons_event_unit: directed scenarios plus random stimulus against a
// time-since-press reference model. Honours BUTTONS_AUTOREPEAT_EN the same way as the design.
module tb_buttons_event_unit;
  import buttons_pkg::*;

  localparam int BC = 4;
  localparam int L  = 10;
  localparam int R  = 4;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst, event_pop, overflow_clear;
  logic [BC-1:0] buttons;
  logic          event_valid, overflow;
  logic [1:0]    event_button;
  event_kind_t   event_kind;

  always #5 clk = ~clk;

  buttons_event_unit #(
    .BUTTON_COUNT    (BC),
    .LONG_PRESS_TICKS(L),
    .REPEAT_TICKS    (R),
    .FIFO_DEPTH      (D)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .buttons       (buttons),
    .event_valid   (event_valid),
    .event_button  (event_button),
    .event_kind    (event_kind),
    .event_pop     (event_pop),
    .overflow      (overflow),
    .overflow_clear(overflow_clear)
  );

  int checks = 0;
  int fails  = 0;

  // Reference model: held[i] = cycles since press (-1 when released), pending slots, event queue.
  int held      [BC];
  bit slot_full [BC];
  int slot_kind [BC];
  int q_btn [$];
  int q_kind [$];
  bit m_ovf;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelStep();
    int win, gk, push_kind;
    bit push, do_pop, any_drop, gen;
    if (rst) begin
      for (int i = 0; i < BC; i++) begin
        held[i] = -1;
        slot_full[i] = 1'b0;
        slot_kind[i] = 0;
      end
      q_btn.delete();
      q_kind.delete();
      m_ovf = 1'b0;
      return;
    end
    do_pop = event_pop && (q_btn.size() > 0);
    win = -1;
    for (int i = BC - 1; i >= 0; i--) if (slot_full[i]) win = i;
    push = (win >= 0) && ((q_btn.size() < D) || do_pop);
    push_kind = push ? slot_kind[win] : 0;
    any_drop = 1'b0;
    for (int i = 0; i < BC; i++) begin
      gen = 1'b0;
      gk  = 0;
      if (held[i] < 0) begin
        if (buttons[i]) begin
          gen = 1'b1; gk = 0; held[i] = 0;
        end
      end else if (!buttons[i]) begin
        gen = 1'b1; gk = 1; held[i] = -1;
      end else begin
        held[i]++;
        if (held[i] == L) begin
          gen = 1'b1; gk = 2;
        end
`ifdef BUTTONS_AUTOREPEAT_EN
        else if (held[i] > L && ((held[i] - L) % R) == 0) begin
          gen = 1'b1; gk = 3;
        end
`endif
      end
      if (push && win == i) slot_full[i] = 1'b0;
      if (gen) begin
        if (slot_full[i]) any_drop = 1'b1;
        else begin
          slot_full[i] = 1'b1;
          slot_kind[i] = gk;
        end
      end
    end
    if (do_pop) begin
      void'(q_btn.pop_front());
      void'(q_kind.pop_front());
    end
    if (push) begin
      q_btn.push_back(win);
      q_kind.push_back(push_kind);
    end
    if (any_drop) m_ovf = 1'b1;
    else if (overflow_clear) m_ovf = 1'b0;
  endtask

  task automatic applyStimulus(input logic [BC-1:0] b, input bit pop, input bit clr, input bit r);
    buttons = b;
    event_pop = pop;
    overflow_clear = clr;
    rst = r;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput("event_valid", event_valid, (q_btn.size() > 0) ? 1 : 0);
    checkOutput("event_button", event_button, (q_btn.size() > 0) ? q_btn[0] : 0);
    checkOutput("event_kind", event_kind, (q_kind.size() > 0) ? q_kind[0] : 0);
    checkOutput("overflow", overflow, m_ovf);
  endtask

  task automatic hold(input logic [BC-1:0] b, input int n, input bit pop);
    for (int k = 0; k < n; k++) applyStimulus(b, pop, 1'b0, 1'b0);
  endtask

  logic [BC-1:0] rb;

  initial begin
    buttons = '0;
    event_pop = 1'b0;
    overflow_clear = 1'b0;
    rst = 1'b1;
    #1;
    applyStimulus('0, 1'b0, 1'b0, 1'b1);
    applyStimulus('0, 1'b0, 1'b0, 1'b1);

    // Short press on button 1: PRESS then RELEASE, no LONG.
    hold(4'b0010, 5, 1'b0);
    hold(4'b0000, 4, 1'b0);
    hold(4'b0000, 4, 1'b1);

    // Long hold on button 0 while draining.
    hold(4'b0001, 20, 1'b1);
    hold(4'b0000, 6, 1'b1);

    // All four buttons rise together; FIFO fills, releases wait in slots.
    hold(4'b1111, 6, 1'b0);
    hold(4'b0000, 6, 1'b0);
    hold(4'b0000, 12, 1'b1);

    // No pops, button 2 toggled every 3 cycles: FIFO fills, slot holds, then drops.
    for (int p = 0; p < 4; p++) begin
      hold(4'b0100, 3, 1'b0);
      hold(4'b0000, 3, 1'b0);
    end
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
    hold(4'b0000, 2, 1'b0);

    // Full FIFO with a pending slot: pop and push in the same cycle, then drain and pop on empty.
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    hold(4'b0000, 2, 1'b0);
    hold(4'b0000, 10, 1'b1);

    // Overflow again, then clear in the same cycle as a drop (drop wins).
    for (int p = 0; p < 4; p++) begin
      hold(4'b0100, 2, 1'b0);
      applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
    end
    hold(4'b0000, 10, 1'b1);

    // Reset with events queued and button 3 held.
    hold(4'b1011, 4, 1'b0);
    applyStimulus(4'b1000, 1'b0, 1'b0, 1'b1);
    hold(4'b1000, 4, 1'b0);
    hold(4'b0000, 6, 1'b1);

    // Random phase.
    rb = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < BC; i++) if ($urandom_range(7) == 0) rb[i] = ~rb[i];
      applyStimulus(rb, $urandom_range(2) == 0, $urandom_range(15) == 0, $urandom_range(199) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
